// File: rtl/dma_channel_engine.sv
// ---------------------------------------------------------------------------
// dma_channel_engine
//
// Single-channel DMA engine. Register writes from the programming stage are
// decoded into the channel registers; a write to the request register starts
// a word-by-word transfer over the shared memory/IO bus (read one word, then
// write it). Supports mem-to-mem, mem-to-IO and IO-to-mem transfers.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   reg_wr            register-write strobe
//   reg_addr          register address (0 base, 1 count, 7 command, 10 mode,
//                     11 mask, 12 request, 13 dest)
//   reg_data          register write data
//   bus_addr          transfer byte address (src in RD, dst in WR, else 0)
//   bus_wdata         write data (latched read word in WR, else 0)
//   bus_rdata         read data, sampled when bus_ready=1 in RD
//   bus_rd, bus_wr    read / write requests, held until bus_ready
//   bus_ready         accept/complete for the current request
//   busy              transfer in progress (RD, WR or DONE)
//   done              one-cycle pulse on normal completion
//   err               sticky reject/abort flag, cleared by an accepted request
// ---------------------------------------------------------------------------
module dma_channel_engine #(
  parameter int IO_BASE = 32764,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reg_wr,
  input  logic [31:0]      reg_addr,
  input  logic [31:0]      reg_data,
  output logic [31:0]      bus_addr,
  output logic [31:0]      bus_wdata,
  input  logic [31:0]      bus_rdata,
  output logic             bus_rd,
  output logic             bus_wr,
  input  logic             bus_ready,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nx;

  // IO_BASE only documents where IO space begins; routing is decided purely
  // by the programmed mode, so nothing is generated from it.
  if (IO_BASE <= 0) begin : g_no_io_space
  end

  // Programmed channel registers
  logic [31:0]      base_q;
  logic [CNT_W-1:0] count_q;
  logic             cmd_m2m_q;
  logic             mode_m2io_q;
  logic             mode_io2m_q;
  logic             mask_q;
  logic [31:0]      dest_q;

  // Working copies used by an active transfer
  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [CNT_W-1:0] rem_q;
  logic             src_inc_q;
  logic             dst_inc_q;
  logic [31:0]      data_q;

  logic idle;
  logic wr_base, wr_count, wr_cmd, wr_mode, wr_mask, wr_req, wr_dest;
  logic sel_m2m, sel_m2io, sel_io2m, mode_ok;
  logic req_accept, req_reject;
  logic rd_fire, wr_fire;

  assign idle     = (state == IDLE);

  assign wr_base  = reg_wr && (reg_addr == 32'd0);
  assign wr_count = reg_wr && (reg_addr == 32'd1);
  assign wr_cmd   = reg_wr && (reg_addr == 32'd7);
  assign wr_mode  = reg_wr && (reg_addr == 32'd10);
  assign wr_mask  = reg_wr && (reg_addr == 32'd11);
  assign wr_req   = reg_wr && (reg_addr == 32'd12);
  assign wr_dest  = reg_wr && (reg_addr == 32'd13);

  // Mode priority: command mem-to-mem beats mem-to-IO beats IO-to-mem.
  assign sel_m2m  = cmd_m2m_q;
  assign sel_m2io = !cmd_m2m_q && mode_m2io_q;
  assign sel_io2m = !cmd_m2m_q && !mode_m2io_q && mode_io2m_q;
  assign mode_ok  = sel_m2m || sel_m2io || sel_io2m;

  assign req_accept = wr_req && idle && !mask_q && (count_q != '0) && mode_ok;
  assign req_reject = wr_req && idle && !req_accept;

  assign rd_fire = (state == RD) && bus_ready;
  assign wr_fire = (state == WR) && bus_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and bus/status outputs. A set mask bit seen at the end of a
  // write means the channel was aborted while busy (it was clear at
  // acceptance), so the engine stops at this word boundary without DONE.
  always_comb begin
    state_nx  = state;
    bus_rd    = 1'b0;
    bus_wr    = 1'b0;
    bus_addr  = 32'd0;
    bus_wdata = 32'd0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (req_accept) state_nx = RD;
      end
      RD: begin
        bus_rd   = 1'b1;
        bus_addr = src_q;
        if (bus_ready) state_nx = WR;
      end
      WR: begin
        bus_wr    = 1'b1;
        bus_addr  = dst_q;
        bus_wdata = data_q;
        if (bus_ready) begin
          if (mask_q)                           state_nx = IDLE;
          else if (rem_q > CNT_W'(1))           state_nx = RD;
          else                                  state_nx = DONE;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        busy     = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  // Channel registers: frozen while busy, except mask which must stay
  // writable so software can abort a running transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q      <= 32'd0;
      count_q     <= CNT_W'(1);
      cmd_m2m_q   <= 1'b0;
      mode_m2io_q <= 1'b0;
      mode_io2m_q <= 1'b0;
      mask_q      <= 1'b1;
      dest_q      <= 32'd0;
    end else begin
      if (wr_base  && idle) base_q  <= reg_data;
      if (wr_count && idle) count_q <= reg_data[CNT_W-1:0];
      if (wr_cmd   && idle) cmd_m2m_q <= reg_data[0];
      if (wr_mode  && idle) begin
        mode_m2io_q <= reg_data[2];
        mode_io2m_q <= reg_data[3];
      end
      if (wr_dest  && idle) dest_q <= reg_data;
      if (wr_mask)          mask_q <= reg_data[0];
    end
  end

  // Sticky error: set on a rejected request or an aborting word boundary,
  // cleared only by a request that is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     err <= 1'b0;
    else if (req_accept)         err <= 1'b0;
    else if (req_reject)         err <= 1'b1;
    else if (wr_fire && mask_q)  err <= 1'b1;
  end

  // Working copies: loaded at acceptance so the programmed registers are
  // never disturbed. The IO side keeps a fixed port address; memory sides
  // step by one word, wrapping naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q     <= 32'd0;
      dst_q     <= 32'd0;
      rem_q     <= '0;
      src_inc_q <= 1'b0;
      dst_inc_q <= 1'b0;
      data_q    <= 32'd0;
    end else begin
      if (req_accept) begin
        src_q     <= sel_io2m ? dest_q : base_q;
        dst_q     <= sel_io2m ? base_q : dest_q;
        src_inc_q <= !sel_io2m;
        dst_inc_q <= !sel_m2io;
        rem_q     <= count_q;
      end
      if (rd_fire) begin
        data_q <= bus_rdata;
        if (src_inc_q) src_q <= src_q + 32'd4;
      end
      if (wr_fire) begin
        if (dst_inc_q) dst_q <= dst_q + 32'd4;
        rem_q <= rem_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dma_channel_engine.sv
// ---------------------------------------------------------------------------
// tb_dma_channel_engine
//
// Directed bench for dma_channel_engine. A small bus responder returns
// read data derived from the address (addr ^ RD_KEY) and can insert a fixed
// number of wait cycles per access. A monitor logs every accepted read and
// write, counts done pulses and watches for request/address changes during
// wait states. Expected addresses and data are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_dma_channel_engine;

  localparam logic [31:0] RD_KEY = 32'h5A5A_0000;

  logic        clk;
  logic        rst;
  logic        reg_wr;
  logic [31:0] reg_addr;
  logic [31:0] reg_data;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_rd;
  logic        bus_wr;
  logic        bus_ready;
  logic        busy;
  logic        done;
  logic        err;

  int compare_count;
  int fail_count;

  int wait_cfg;
  int wcnt;

  logic [31:0] rd_log[$];
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  int          done_cnt;
  int          hold_viol;

  logic        prev_pending;
  logic [31:0] prev_addr;
  logic [31:0] prev_wdata;
  logic        prev_rd;
  logic        prev_wr;

  dma_channel_engine #(.IO_BASE(32764), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .reg_wr    (reg_wr),
    .reg_addr  (reg_addr),
    .reg_data  (reg_data),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_rd    (bus_rd),
    .bus_wr    (bus_wr),
    .bus_ready (bus_ready),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus responder: ready after wait_cfg stalled cycles of each access
  assign bus_ready = (wait_cfg == 0) || (wcnt == wait_cfg);
  assign bus_rdata = bus_addr ^ RD_KEY;

  always @(posedge clk) begin
    if (!(bus_rd || bus_wr) || bus_ready) wcnt <= 0;
    else                                  wcnt <= wcnt + 1;
  end

  // Monitor, sampled mid-cycle where everything is settled
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_rd && bus_ready) rd_log.push_back(bus_addr);
      if (bus_wr && bus_ready) begin
        wr_addr_log.push_back(bus_addr);
        wr_data_log.push_back(bus_wdata);
      end
      if (done) done_cnt++;
      if (prev_pending &&
          (bus_addr != prev_addr || bus_rd != prev_rd || bus_wr != prev_wr ||
           (bus_wr && bus_wdata != prev_wdata)))
        hold_viol++;
    end
    prev_pending = (bus_rd || bus_wr) && !bus_ready;
    prev_addr    = bus_addr;
    prev_wdata   = bus_wdata;
    prev_rd      = bus_rd;
    prev_wr      = bus_wr;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compare_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One register write; called and returns just after a rising edge
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
    reg_wr   = 1'b1;
    reg_addr = addr;
    reg_data = data;
    @(posedge clk);
    #1;
    reg_wr   = 1'b0;
    reg_addr = 32'd0;
    reg_data = 32'd0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitDone(input string tag);
    int k;
    k = 0;
    while (!done && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    checkOutput(tag, {31'd0, done}, 32'd1);
    tick(1);
  endtask

  task automatic clearLogs();
    rd_log.delete();
    wr_addr_log.delete();
    wr_data_log.delete();
    done_cnt = 0;
  endtask

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  initial begin
    int k;
    compare_count = 0;
    fail_count    = 0;
    wait_cfg      = 0;
    hold_viol     = 0;
    done_cnt      = 0;
    reg_wr        = 1'b0;
    reg_addr      = 32'd0;
    reg_data      = 32'd0;
    rst           = 1'b1;
    #1;
    checkOutput("rst_busy",  {31'd0, busy},   32'd0);
    checkOutput("rst_rd_wr", {30'd0, bus_rd, bus_wr}, 32'd0);
    checkOutput("rst_err",   {31'd0, err},    32'd0);
    checkOutput("rst_addr",  bus_addr,        32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(1);

    // ---- Mem-to-mem, zero-wait -------------------------------------------
    $display("[TB] mem-to-mem");
    applyStimulus(32'd0,  32'h100);
    applyStimulus(32'd13, 32'h200);
    applyStimulus(32'd1,  32'd3);
    applyStimulus(32'd7,  32'd1);
    applyStimulus(32'd11, 32'd0);
    clearLogs();
    applyStimulus(32'd12, 32'd0);
    checkOutput("t1_busy_start", {31'd0, busy},   32'd1);
    checkOutput("t1_rd_start",   {31'd0, bus_rd}, 32'd1);
    checkOutput("t1_addr_start", bus_addr,        32'h100);
    k = 0;
    while (!done && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    checkOutput("t1_done_cycles", k, 32'd6);
    checkOutput("t1_busy_in_done", {31'd0, busy}, 32'd1);
    checkOutput("t1_err", {31'd0, err}, 32'd0);
    tick(1);
    checkOutput("t1_done_pulse", {31'd0, done}, 32'd0);
    checkOutput("t1_busy_end",   {31'd0, busy}, 32'd0);
    checkOutput("t1_rd_n", rd_log.size(), 32'd3);
    checkOutput("t1_rd0", q_at(rd_log, 0), 32'h100);
    checkOutput("t1_rd1", q_at(rd_log, 1), 32'h104);
    checkOutput("t1_rd2", q_at(rd_log, 2), 32'h108);
    checkOutput("t1_wr_n", wr_addr_log.size(), 32'd3);
    checkOutput("t1_wa0", q_at(wr_addr_log, 0), 32'h200);
    checkOutput("t1_wa1", q_at(wr_addr_log, 1), 32'h204);
    checkOutput("t1_wa2", q_at(wr_addr_log, 2), 32'h208);
    checkOutput("t1_wd0", q_at(wr_data_log, 0), 32'h5A5A_0100);
    checkOutput("t1_wd2", q_at(wr_data_log, 2), 32'h5A5A_0108);

    // ---- Mem-to-IO with two wait cycles per access ------------------------
    $display("[TB] mem-to-io with waits");
    applyStimulus(32'd7,  32'd0);
    applyStimulus(32'd0,  32'h40);
    applyStimulus(32'd13, 32'h9000);
    applyStimulus(32'd10, 32'd4);
    applyStimulus(32'd1,  32'd2);
    wait_cfg  = 2;
    hold_viol = 0;
    clearLogs();
    applyStimulus(32'd12, 32'd0);
    waitDone("t2_done");
    checkOutput("t2_hold", hold_viol, 32'd0);
    checkOutput("t2_rd_n", rd_log.size(), 32'd2);
    checkOutput("t2_rd0", q_at(rd_log, 0), 32'h40);
    checkOutput("t2_rd1", q_at(rd_log, 1), 32'h44);
    checkOutput("t2_wa0", q_at(wr_addr_log, 0), 32'h9000);
    checkOutput("t2_wa1", q_at(wr_addr_log, 1), 32'h9000);
    checkOutput("t2_wd1", q_at(wr_data_log, 1), 32'h5A5A_0044);
    wait_cfg = 0;

    // ---- IO-to-mem with default count -------------------------------------
    $display("[TB] io-to-mem default count");
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    applyStimulus(32'd13, 32'h8004);
    applyStimulus(32'd0,  32'h10);
    applyStimulus(32'd10, 32'd8);
    applyStimulus(32'd11, 32'd0);
    clearLogs();
    applyStimulus(32'd12, 32'd0);
    waitDone("t3_done");
    checkOutput("t3_rd_n", rd_log.size(), 32'd1);
    checkOutput("t3_rd0", q_at(rd_log, 0), 32'h8004);
    checkOutput("t3_wr_n", wr_addr_log.size(), 32'd1);
    checkOutput("t3_wa0", q_at(wr_addr_log, 0), 32'h10);
    checkOutput("t3_wd0", q_at(wr_data_log, 0), 32'h5A5A_8004);
    checkOutput("t3_err", {31'd0, err}, 32'd0);

    // ---- Rejections, each followed by a clearing valid request ------------
    $display("[TB] rejections");
    applyStimulus(32'd11, 32'd1);
    clearLogs();
    applyStimulus(32'd12, 32'd0);
    checkOutput("t4_mask_err",  {31'd0, err},  32'd1);
    checkOutput("t4_mask_busy", {31'd0, busy}, 32'd0);
    tick(2);
    checkOutput("t4_mask_nord", rd_log.size(), 32'd0);
    applyStimulus(32'd11, 32'd0);
    applyStimulus(32'd12, 32'd0);
    checkOutput("t4_clear1", {31'd0, err}, 32'd0);
    waitDone("t4_done1");

    applyStimulus(32'd1, 32'd0);
    clearLogs();
    applyStimulus(32'd12, 32'd0);
    checkOutput("t4_cnt0_err", {31'd0, err}, 32'd1);
    tick(2);
    checkOutput("t4_cnt0_nord", rd_log.size(), 32'd0);
    applyStimulus(32'd1, 32'd1);
    applyStimulus(32'd12, 32'd0);
    checkOutput("t4_clear2", {31'd0, err}, 32'd0);
    waitDone("t4_done2");

    applyStimulus(32'd10, 32'd0);
    clearLogs();
    applyStimulus(32'd12, 32'd0);
    checkOutput("t4_nomode_err", {31'd0, err}, 32'd1);
    tick(2);
    checkOutput("t4_nomode_nord", rd_log.size(), 32'd0);
    applyStimulus(32'd10, 32'd8);
    applyStimulus(32'd12, 32'd0);
    checkOutput("t4_clear3", {31'd0, err}, 32'd0);
    waitDone("t4_done3");

    // ---- Abort during word 2 read -----------------------------------------
    $display("[TB] abort");
    applyStimulus(32'd7,  32'd1);
    applyStimulus(32'd0,  32'h300);
    applyStimulus(32'd13, 32'h400);
    applyStimulus(32'd1,  32'd4);
    clearLogs();
    applyStimulus(32'd12, 32'd0);
    tick(2);
    checkOutput("t5_in_rd2", bus_addr, 32'h304);
    applyStimulus(32'd11, 32'd1);
    tick(6);
    checkOutput("t5_rd_n", rd_log.size(), 32'd2);
    checkOutput("t5_wr_n", wr_addr_log.size(), 32'd2);
    checkOutput("t5_wa1", q_at(wr_addr_log, 1), 32'h404);
    checkOutput("t5_wd1", q_at(wr_data_log, 1), 32'h5A5A_0304);
    checkOutput("t5_done", done_cnt, 32'd0);
    checkOutput("t5_err",  {31'd0, err},  32'd1);
    checkOutput("t5_busy", {31'd0, busy}, 32'd0);

    // ---- Reset mid-write, then address wrap -------------------------------
    $display("[TB] reset mid-write and wrap");
    applyStimulus(32'd0,  32'h500);
    applyStimulus(32'd13, 32'h600);
    applyStimulus(32'd1,  32'd2);
    applyStimulus(32'd11, 32'd0);
    wait_cfg = 2;
    applyStimulus(32'd12, 32'd0);
    k = 0;
    while (!bus_wr && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    checkOutput("t6_saw_wr", {31'd0, bus_wr}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_wr",    {31'd0, bus_wr}, 32'd0);
    checkOutput("t6_rst_rd",    {31'd0, bus_rd}, 32'd0);
    checkOutput("t6_rst_busy",  {31'd0, busy},   32'd0);
    checkOutput("t6_rst_done",  {31'd0, done},   32'd0);
    checkOutput("t6_rst_addr",  bus_addr,        32'd0);
    checkOutput("t6_rst_wdata", bus_wdata,       32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    wait_cfg = 0;
    tick(1);
    applyStimulus(32'd12, 32'd0);
    checkOutput("t6_mask_default", {31'd0, err}, 32'd1);
    applyStimulus(32'd7,  32'd1);
    applyStimulus(32'd0,  32'hFFFF_FFFC);
    applyStimulus(32'd13, 32'h700);
    applyStimulus(32'd1,  32'd2);
    applyStimulus(32'd11, 32'd0);
    clearLogs();
    applyStimulus(32'd12, 32'd0);
    waitDone("t6_done");
    checkOutput("t6_rd_n", rd_log.size(), 32'd2);
    checkOutput("t6_rd0", q_at(rd_log, 0), 32'hFFFF_FFFC);
    checkOutput("t6_rd1", q_at(rd_log, 1), 32'h0000_0000);
    checkOutput("t6_wa1", q_at(wr_addr_log, 1), 32'h704);
    checkOutput("t6_wd0", q_at(wr_data_log, 0), 32'hA5A5_FFFC);
    checkOutput("t6_wd1", q_at(wr_data_log, 1), 32'h5A5A_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
